led_frame_scheduler: RTL and testbench

Sequences 256-bit frames into the serial shift-register chain of the 16x16 LED matrix. Accepts frames from the game/render logic over a valid/ready handshake and buffers one pending frame. Generates the data, shift-clock and store-clock waveforms at a programmable bit rate, then pulses a frame-done strobe. Sits between the board renderer and the matrix pins, replacing free-running serialisation with frame-coherent updates.

---
 rtl/led_pkg.sv | 15 +
 rtl/led_phase_timer.sv | 38 +++
 rtl/led_frame_scheduler.sv | 172 +++++++++++++++++
 tb/tb_led_frame_scheduler.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared constants and state type for the LED frame scheduler
package led_pkg;

    localparam int MATRIX_DIM = 16;
    localparam int FRAME_BITS = MATRIX_DIM * MATRIX_DIM;
    localparam int BIT_CNT_W  = $clog2(FRAME_BITS);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH
    } led_sched_state_t;

endpackage

// File: rtl/led_phase_timer.sv
// rtl/led_phase_timer.sv - per-phase down-counter that flags the last cycle of a phase
// Ports: clk_i/rst_i clock and async active-high reset; load_i restarts the phase;
//        phase_end_o is high in the final cycle of the current phase.
module led_phase_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    output logic phase_end_o
);

    localparam int            CW     = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = RELOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A freshly loaded count of CLK_DIV-1 reaches zero in the CLK_DIV-th cycle.
    assign phase_end_o = (cnt_q == '0);

endmodule

// File: rtl/led_frame_scheduler.sv
// rtl/led_frame_scheduler.sv - frame-coherent serialiser for the 16x16 LED shift chain
// Ports: iClk/iReset clock and async active-high reset; iFrame/iFrameValid/oFrameReady
//        frame handshake; oData/oShiftClk/oStoreClk chain pins; oBusy/oFrameDone status.
// Build option: LED_REPEAT_EN - keep refreshing the last frame instead of returning to IDLE.
module led_frame_scheduler
    import led_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                  iClk,
    input  logic                  iReset,
    input  logic [FRAME_BITS-1:0] iFrame,
    input  logic                  iFrameValid,
    output logic                  oFrameReady,
    output logic                  oData,
    output logic                  oShiftClk,
    output logic                  oStoreClk,
    output logic                  oBusy,
    output logic                  oFrameDone
);

    led_sched_state_t state_q, state_d;

    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [FRAME_BITS-1:0] pend_data_q, pend_data_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;

    logic data_q, data_d;
    logic shift_clk_q, store_clk_q, busy_q, ready_q;
    logic done_q, done_d;

    logic accept, pull, phase_end, timer_load;

`ifdef LED_REPEAT_EN
    logic [FRAME_BITS-1:0] last_q, last_d;
`endif

    // Every state change starts a new CLK_DIV-long phase.
    assign timer_load = (state_d != state_q);

    led_phase_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_phase_timer (
        .clk_i       (iClk),
        .rst_i       (iReset),
        .load_i      (timer_load),
        .phase_end_o (phase_end)
    );

    assign accept = iFrameValid && ready_q;

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        pend_data_d  = pend_data_q;
        pend_valid_d = pend_valid_q;
        done_d       = 1'b0;
        pull         = 1'b0;
`ifdef LED_REPEAT_EN
        last_d       = last_q;
`endif

        case (state_q)
            IDLE: begin
                if (pend_valid_q) begin
                    pull = 1'b1;
                end
            end
            SHIFT_LO: begin
                if (phase_end) begin
                    state_d = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (phase_end) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    state_d   = (bit_cnt_q == {BIT_CNT_W{1'b1}}) ? LATCH : SHIFT_LO;
                end
            end
            LATCH: begin
                if (phase_end) begin
                    done_d = 1'b1;
                    if (pend_valid_q) begin
                        pull = 1'b1;
                    end else begin
`ifdef LED_REPEAT_EN
                        shift_d   = last_q;
                        bit_cnt_d = '0;
                        state_d   = SHIFT_LO;
`else
                        state_d   = IDLE;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Engine pull reads the slot's current contents; a same-edge accept refills it.
        if (pull) begin
            shift_d      = pend_data_q;
            bit_cnt_d    = '0;
            state_d      = SHIFT_LO;
            pend_valid_d = 1'b0;
`ifdef LED_REPEAT_EN
            last_d       = pend_data_q;
`endif
        end

        if (accept) begin
            pend_data_d  = iFrame;
            pend_valid_d = 1'b1;
        end

        // Data only moves on SHIFT_LO entry, giving CLK_DIV cycles of setup and hold.
        data_d = data_q;
        if (state_d == IDLE) begin
            data_d = 1'b0;
        end else if (state_d == SHIFT_LO) begin
            data_d = shift_d[0];
        end
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            pend_data_q  <= '0;
            pend_valid_q <= 1'b0;
            bit_cnt_q    <= '0;
            data_q       <= 1'b0;
            shift_clk_q  <= 1'b0;
            store_clk_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            pend_data_q  <= pend_data_d;
            pend_valid_q <= pend_valid_d;
            bit_cnt_q    <= bit_cnt_d;
            data_q       <= data_d;
            shift_clk_q  <= (state_d == SHIFT_HI);
            store_clk_q  <= (state_d == LATCH);
            busy_q       <= (state_d != IDLE);
            done_q       <= done_d;
            ready_q      <= !pend_valid_d;
        end
    end

`ifdef LED_REPEAT_EN
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            last_q <= '0;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign oFrameReady = ready_q;
    assign oData       = data_q;
    assign oShiftClk   = shift_clk_q;
    assign oStoreClk   = store_clk_q;
    assign oBusy       = busy_q;
    assign oFrameDone  = done_q;

endmodule

// File: tb/tb_led_frame_scheduler.sv
// tb/tb_led_frame_scheduler.sv - directed self-checking bench for led_frame_scheduler
module tb_led_frame_scheduler;
    import led_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [FRAME_BITS-1:0] frame1 = '0;
    logic [FRAME_BITS-1:0] frame4 = '0;
    logic valid1 = 1'b0;
    logic valid4 = 1'b0;
    logic ready1, data1, sclk1, stclk1, busy1, done1;
    logic ready4, data4, sclk4, stclk4, busy4, done4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    led_frame_scheduler #(.CLK_DIV(1)) dut1 (
        .iClk(clk), .iReset(rst), .iFrame(frame1), .iFrameValid(valid1),
        .oFrameReady(ready1), .oData(data1), .oShiftClk(sclk1),
        .oStoreClk(stclk1), .oBusy(busy1), .oFrameDone(done1)
    );

    led_frame_scheduler #(.CLK_DIV(4)) dut4 (
        .iClk(clk), .iReset(rst), .iFrame(frame4), .iFrameValid(valid4),
        .oFrameReady(ready4), .oData(data4), .oShiftClk(sclk4),
        .oStoreClk(stclk4), .oBusy(busy4), .oFrameDone(done4)
    );

    // Observer for the CLK_DIV=4 instance: captures the serial stream on shift-clock rises.
    int cyc = 0;
    logic [FRAME_BITS-1:0] cap4 = '0;
    logic [FRAME_BITS-1:0] seen4 = '0;
    int bit4 = 0, hi4 = 0, seen_bits4 = 0, seen_hi4 = 0;
    int done_cnt4 = 0, done_cyc4 = 0, first_rise4 = 0, last_rise4 = 0;
    int gap_err4 = 0, data_err4 = 0, busy_lo4 = 0, st_rise4 = 0;
    logic sclk4_p = 1'b0, stclk4_p = 1'b0, data4_p = 1'b0;

    always @(negedge clk) begin
        cyc      <= cyc + 1;
        sclk4_p  <= sclk4;
        stclk4_p <= stclk4;
        data4_p  <= data4;
        if (!busy4) busy_lo4 <= busy_lo4 + 1;
        if (stclk4 && !stclk4_p) st_rise4 <= st_rise4 + 1;
        if (rst) begin
            bit4 <= 0;
            hi4  <= 0;
        end else if (done4) begin
            seen4      <= cap4;
            seen_bits4 <= bit4;
            seen_hi4   <= hi4;
            bit4       <= 0;
            hi4        <= 0;
            done_cnt4  <= done_cnt4 + 1;
            done_cyc4  <= cyc + 1;
        end else begin
            if (sclk4) hi4 <= hi4 + 1;
            if (sclk4 && data4 !== data4_p) data_err4 <= data_err4 + 1;
            if (sclk4 && !sclk4_p) begin
                if (bit4 < FRAME_BITS) cap4[bit4[7:0]] <= data4;
                if (bit4 == 0) first_rise4 <= cyc + 1;
                else if (cyc - last_rise4 != 8) gap_err4 <= gap_err4 + 1;
                last_rise4 <= cyc;
                bit4       <= bit4 + 1;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        valid1 = 1'b0;
        valid4 = 1'b0;
        rst    = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
    endtask

    task automatic wait_done4(input int budget, output bit ok);
        int d0;
        d0 = done_cnt4;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done_cnt4 != d0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if ({data4, sclk4, stclk4, busy4, done4, ready4} !== 6'b0) begin
            failures++; $display("FAIL reset_outputs4 got=%b exp=000000", {data4, sclk4, stclk4, busy4, done4, ready4}); end
        checks++; if ({data1, sclk1, stclk1, busy1, done1, ready1} !== 6'b0) begin
            failures++; $display("FAIL reset_outputs1 got=%b exp=000000", {data1, sclk1, stclk1, busy1, done1, ready1}); end
        rst = 1'b0;
        #1;
        checks++; if (ready4 !== 1'b0) begin
            failures++; $display("FAIL ready_before_edge got=%b exp=0", ready4); end
        tick();
        checks++; if (ready4 !== 1'b1) begin
            failures++; $display("FAIL ready_after_edge4 got=%b exp=1", ready4); end
        checks++; if (ready1 !== 1'b1) begin
            failures++; $display("FAIL ready_after_edge1 got=%b exp=1", ready1); end
    endtask

    task automatic test_div1_single();
        int rises, first_k, first_one, other_one, st_cyc, done_k, done_n;
        logic p_s;
        rises = 0; first_k = 0; first_one = 0; other_one = 0;
        st_cyc = 0; done_k = 0; done_n = 0;
        frame1 = 256'h1;
        valid1 = 1'b1;
        tick();
        valid1 = 1'b0;
        checks++; if (ready1 !== 1'b0) begin
            failures++; $display("FAIL div1_ready_full got=%b exp=0", ready1); end
        p_s = sclk1;
        for (int k = 1; k <= 514; k++) begin
            tick();
            if (k == 1) begin
                checks++; if ({busy1, data1, ready1} !== 3'b111) begin
                    failures++; $display("FAIL div1_first_cycle got=%b exp=111", {busy1, data1, ready1}); end
            end
            if (sclk1 && !p_s) begin
                rises++;
                if (rises == 1) first_k = k;
                if (data1) begin
                    if (rises == 1) first_one++;
                    else other_one++;
                end
            end
            p_s = sclk1;
            if (stclk1) st_cyc++;
            if (done1) begin
                done_n++;
                if (done_k == 0) done_k = k;
            end
        end
        checks++; if (rises !== 256) begin
            failures++; $display("FAIL div1_rises got=%0d exp=256", rises); end
        checks++; if (first_k !== 2) begin
            failures++; $display("FAIL div1_first_rise got=%0d exp=2", first_k); end
        checks++; if (first_one !== 1 || other_one !== 0) begin
            failures++; $display("FAIL div1_data_ones got=%0d/%0d exp=1/0", first_one, other_one); end
        checks++; if (st_cyc !== 1) begin
            failures++; $display("FAIL div1_store_cycles got=%0d exp=1", st_cyc); end
        checks++; if (done_k !== 514 || done_n !== 1) begin
            failures++; $display("FAIL div1_done got=%0d/%0d exp=514/1", done_k, done_n); end
`ifdef LED_REPEAT_EN
        checks++; if (busy1 !== 1'b1) begin
            failures++; $display("FAIL div1_busy_end got=%b exp=1", busy1); end
`else
        checks++; if (busy1 !== 1'b0) begin
            failures++; $display("FAIL div1_busy_end got=%b exp=0", busy1); end
`endif
    endtask

    task automatic test_div4_pattern();
        logic [FRAME_BITS-1:0] f;
        int acc0, ge0, de0;
        bit ok;
        f = {128{2'b10}};
        do_reset();
        ge0 = gap_err4;
        de0 = data_err4;
        frame4 = f;
        valid4 = 1'b1;
        tick();
        valid4 = 1'b0;
        acc0 = cyc;
        wait_done4(3000, ok);
        checks++; if (ok !== 1'b1) begin
            failures++; $display("FAIL div4_done_timeout got=%b exp=1", ok); end
        checks++; if (done_cyc4 - acc0 !== 2053) begin
            failures++; $display("FAIL div4_done_cycle got=%0d exp=2053", done_cyc4 - acc0); end
        checks++; if (first_rise4 - acc0 !== 5) begin
            failures++; $display("FAIL div4_first_rise got=%0d exp=5", first_rise4 - acc0); end
        checks++; if (seen4 !== f) begin
            failures++; $display("FAIL div4_stream got=%h exp=%h", seen4, f); end
        checks++; if (seen_bits4 !== 256 || seen_hi4 !== 1024) begin
            failures++; $display("FAIL div4_bits_high got=%0d/%0d exp=256/1024", seen_bits4, seen_hi4); end
        checks++; if (gap_err4 - ge0 !== 0) begin
            failures++; $display("FAIL div4_period got=%0d exp=0", gap_err4 - ge0); end
        checks++; if (data_err4 - de0 !== 0) begin
            failures++; $display("FAIL div4_data_hold got=%0d exp=0", data_err4 - de0); end
`ifdef LED_REPEAT_EN
        checks++; if ({busy4, data4} !== {1'b1, f[0]}) begin
            failures++; $display("FAIL div4_after_done got=%b exp=1%b", {busy4, data4}, f[0]); end
`else
        checks++; if ({busy4, data4, sclk4, stclk4} !== 4'b0) begin
            failures++; $display("FAIL div4_after_done got=%b exp=0000", {busy4, data4, sclk4, stclk4}); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [FRAME_BITS-1:0] fa, fb, fc;
        int ready_hi, d_prev;
        bit ok;
        fa = {8{32'hDEADBEEF}};
        fb = {8{32'h12345678}};
        fc = {8{32'h0F0FF0F1}};
        do_reset();
        frame4 = fa;
        valid4 = 1'b1;
        tick();
        valid4 = 1'b0;
        repeat (9) tick();
        checks++; if (ready4 !== 1'b1) begin
            failures++; $display("FAIL b2b_slot_empty got=%b exp=1", ready4); end
        frame4 = fb;
        valid4 = 1'b1;
        tick();
        checks++; if (ready4 !== 1'b0) begin
            failures++; $display("FAIL b2b_b_accepted got=%b exp=0", ready4); end
        frame4 = fc;
        ready_hi = 0;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (done4) begin
                ok = 1'b1;
                break;
            end
            if (ready4) ready_hi++;
        end
        checks++; if (ok !== 1'b1 || ready_hi !== 0) begin
            failures++; $display("FAIL b2b_ready_held got=%b/%0d exp=1/0", ok, ready_hi); end
        tick();
        checks++; if (seen4 !== fa) begin
            failures++; $display("FAIL b2b_stream_a got=%h exp=%h", seen4, fa); end
        d_prev = done_cyc4;
        checks++; if ({busy4, sclk4, stclk4, data4} !== {3'b100, fb[0]}) begin
            failures++; $display("FAIL b2b_b_started got=%b exp=100%b", {busy4, sclk4, stclk4, data4}, fb[0]); end
        checks++; if (ready4 !== 1'b0) begin
            failures++; $display("FAIL b2b_c_accepted got=%b exp=0", ready4); end
        valid4 = 1'b0;
        wait_done4(3000, ok);
        checks++; if (ok !== 1'b1 || seen4 !== fb) begin
            failures++; $display("FAIL b2b_stream_b got=%h exp=%h", seen4, fb); end
        checks++; if (done_cyc4 - d_prev !== 2052) begin
            failures++; $display("FAIL b2b_frame_period got=%0d exp=2052", done_cyc4 - d_prev); end
        checks++; if ({busy4, data4} !== {1'b1, fc[0]}) begin
            failures++; $display("FAIL b2b_c_started got=%b exp=1%b", {busy4, data4}, fc[0]); end
        wait_done4(3000, ok);
        checks++; if (ok !== 1'b1 || seen4 !== fc) begin
            failures++; $display("FAIL b2b_stream_c got=%h exp=%h", seen4, fc); end
    endtask

    task automatic test_reset_mid_frame();
        logic [FRAME_BITS-1:0] fd, fe;
        int st0, dc0;
        bit ok;
        fd = '1;
        fe = {16{16'hC3A5}};
        do_reset();
        frame4 = fd;
        valid4 = 1'b1;
        tick();
        valid4 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            tick();
            if (bit4 >= 100) begin
                ok = 1'b1;
                break;
            end
        end
        checks++; if (ok !== 1'b1) begin
            failures++; $display("FAIL rst_mid_reach_bit100 got=%b exp=1", ok); end
        st0 = st_rise4;
        dc0 = done_cnt4;
        rst = 1'b1;
        #1;
        checks++; if ({data4, sclk4, stclk4, busy4, done4, ready4} !== 6'b0) begin
            failures++; $display("FAIL rst_mid_async got=%b exp=000000", {data4, sclk4, stclk4, busy4, done4, ready4}); end
        repeat (3) tick();
        rst = 1'b0;
        tick();
        frame4 = fe;
        valid4 = 1'b1;
        tick();
        valid4 = 1'b0;
        wait_done4(3000, ok);
        checks++; if (ok !== 1'b1 || seen4 !== fe || seen_bits4 !== 256) begin
            failures++; $display("FAIL rst_mid_new_frame got=%h/%0d exp=%h/256", seen4, seen_bits4, fe); end
        checks++; if (st_rise4 - st0 !== 1 || done_cnt4 - dc0 !== 1) begin
            failures++; $display("FAIL rst_mid_no_latch got=%0d/%0d exp=1/1", st_rise4 - st0, done_cnt4 - dc0); end
    endtask

`ifdef LED_REPEAT_EN
    task automatic test_repeat();
        logic [FRAME_BITS-1:0] ff;
        int d1, bl0;
        bit ok;
        ff = {4{64'h0123456789ABCDEF}};
        do_reset();
        frame4 = ff;
        valid4 = 1'b1;
        tick();
        valid4 = 1'b0;
        wait_done4(3000, ok);
        d1  = done_cyc4;
        bl0 = busy_lo4;
        wait_done4(3000, ok);
        checks++; if (ok !== 1'b1 || done_cyc4 - d1 !== 2052) begin
            failures++; $display("FAIL repeat_period1 got=%0d exp=2052", done_cyc4 - d1); end
        checks++; if (seen4 !== ff) begin
            failures++; $display("FAIL repeat_stream got=%h exp=%h", seen4, ff); end
        d1 = done_cyc4;
        wait_done4(3000, ok);
        checks++; if (ok !== 1'b1 || done_cyc4 - d1 !== 2052) begin
            failures++; $display("FAIL repeat_period2 got=%0d exp=2052", done_cyc4 - d1); end
        checks++; if (busy_lo4 - bl0 !== 0) begin
            failures++; $display("FAIL repeat_busy got=%0d exp=0", busy_lo4 - bl0); end
    endtask
`else
    task automatic test_idle_hold();
        int dc0, bl0;
        bit ok;
        do_reset();
        frame4 = {4{64'hFEDCBA9876543210}};
        valid4 = 1'b1;
        tick();
        valid4 = 1'b0;
        wait_done4(3000, ok);
        dc0 = done_cnt4;
        bl0 = busy_lo4;
        repeat (40) tick();
        checks++; if (ok !== 1'b1 || done_cnt4 !== dc0) begin
            failures++; $display("FAIL idle_no_refresh got=%0d exp=%0d", done_cnt4, dc0); end
        checks++; if (busy_lo4 - bl0 !== 40) begin
            failures++; $display("FAIL idle_busy_low got=%0d exp=40", busy_lo4 - bl0); end
        checks++; if ({data4, sclk4, stclk4} !== 3'b0) begin
            failures++; $display("FAIL idle_pins got=%b exp=000", {data4, sclk4, stclk4}); end
    endtask
`endif

    initial begin
        test_reset();
        test_div1_single();
        test_div4_pattern();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef LED_REPEAT_EN
        test_repeat();
`else
        test_idle_hold();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
